demux_serializer: RTL and testbench

//  Upstream driver for the 1-to-4 demux (ports s0,s1,I,en). Accepts a parallel word plus a 2-bit

---
 rtl/demux_serializer_pkg.sv | 16 +
 rtl/demux_shreg.sv | 31 +++
 rtl/demux_serializer.sv | 109 ++++++++++
 tb/tb_demux_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_serializer_pkg.sv
// Shared types and constants for the demux serializer.
// FSM state encoding and demux channel codes.
package demux_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CH_D0 = 2'd0;
  localparam logic [1:0] CH_D1 = 2'd1;
  localparam logic [1:0] CH_D2 = 2'd2;
  localparam logic [1:0] CH_D3 = 2'd3;

endpackage

// File: rtl/demux_shreg.sv
// Loadable shift register feeding the serial line.
// Head bit is a flop output; shifts toward it and fills with 0.
module demux_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sr;

  // load wins over shift; an emptied register presents 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign dout = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/demux_serializer.sv
// Serializes a word onto I with registered select/enable
// for a downstream 1-to-4 demux.
module demux_serializer
  import demux_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_ch,
  output logic             s0,
  output logic             s1,
  output logic             I,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BLAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BPEN  = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          take;

  assign in_ready = (state == ST_IDLE);
  assign take     = in_valid & in_ready;

  demux_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (take),
    .shift(state == ST_SHIFT),
    .din  (in_data),
    .dout (I)
  );

  // sequencing plus registered select, enable, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      en    <= 1'b0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take) begin
            s0    <= in_ch[1];
            s1    <= in_ch[0];
            en    <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == BLAST) begin
            en   <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            gcnt <= '0;
            if (GAP == 0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            cnt  <= cnt + CW'(1);
            done <= (cnt == BPEN);
          end
        end
        ST_GAP: begin
          if (gcnt == GLAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_serializer.sv
// Bench: MSB-first and LSB-first serializers share one stimulus;
// a demux model steers each I bit to d0..d3.
module tb_demux_serializer;

  localparam int W = 8;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_ch;

  logic rdy_m, s0_m, s1_m, i_m, en_m, busy_m, done_m;
  logic rdy_l, s0_l, s1_l, i_l, en_l, busy_l, done_l;

  int  total = 0;
  int  bad   = 0;
  logic [1:0] last_ch = 2'd0;
  time last_hs = 0;

  always #5 clk = ~clk;

  demux_serializer #(.WIDTH(W), .GAP(G), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .in_ch(in_ch), .s0(s0_m), .s1(s1_m),
    .I(i_m), .en(en_m), .busy(busy_m), .done(done_m)
  );

  demux_serializer #(.WIDTH(W), .GAP(G), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .in_ch(in_ch), .s0(s0_l), .s1(s1_l),
    .I(i_l), .en(en_l), .busy(busy_l), .done(done_l)
  );

  // 1-to-4 demux model: d[{s0,s1}] = I when enabled
  function automatic logic [3:0] dvec(logic e, logic i, logic [1:0] s);
    if (e !== 1'b1) return 4'd0;
    return {3'd0, i} << s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag, bit e_en, bit e_im, bit e_il,
                         bit [1:0] e_ch, bit e_busy, bit e_done,
                         bit e_rdy);
    chk({tag, ".en"},   {en_l, en_m},     {e_en, e_en});
    chk({tag, ".I_m"},  i_m,              e_im);
    chk({tag, ".I_l"},  i_l,              e_il);
    chk({tag, ".sel"},  {s0_m, s1_m, s0_l, s1_l}, {e_ch, e_ch});
    chk({tag, ".busy"}, {busy_l, busy_m}, {e_busy, e_busy});
    chk({tag, ".done"}, {done_l, done_m}, {e_done, e_done});
    chk({tag, ".rdy"},  {rdy_l, rdy_m},   {e_rdy, e_rdy});
    chk({tag, ".d"},
        {dvec(en_m, i_m, {s0_m, s1_m}), dvec(en_l, i_l, {s0_l, s1_l})},
        {(e_en & e_im) ? 4'd1 << e_ch : 4'd0,
         (e_en & e_il) ? 4'd1 << e_ch : 4'd0});
  endtask

  task automatic scramble();
    in_data  = 8'($urandom);
    in_ch    = 2'($urandom);
    in_valid = 1'($urandom);
  endtask

  // wait for IDLE, handshake, then check every bit and gap cycle
  task automatic send(input logic [7:0] d, input logic [1:0] c,
                      input bit hold, input bit scr, input bit spacing,
                      input int nbits);
    int n;
    bit bm, bl;
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = c;
    n = 0;
    while (!(rdy_m === 1'b1 && rdy_l === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 0, 1);
    chk("idle.sel", {en_m, s0_m, s1_m}, {1'b0, last_ch});
    @(posedge clk);
    if (spacing) chk("spacing", 32'($time - last_hs), 32'((W + G + 1) * 10));
    last_hs = $time;
    last_ch = c;
    #1;
    if (scr) scramble();
    else in_valid = hold;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      bm = 1'((int'(d) >> (W - 1 - k)) & 1);
      bl = 1'((int'(d) >> k) & 1);
      chk_all($sformatf("bit%0d", k), 1'b1, bm, bl, c, 1'b1,
              k == W - 1, 1'b0);
      if (scr) scramble();
    end
    if (nbits < W) return;
    for (int g = 0; g < G; g++) begin
      @(negedge clk);
      chk_all("gap", 1'b0, 1'b0, 1'b0, c, 1'b1, 1'b0, 1'b0);
      if (scr) scramble();
    end
    in_valid = hold;
  endtask

  initial begin
    int idle;
    logic [7:0] d;
    logic [1:0] c;
    bit hold, prev_hold, scr;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    in_ch    = 2'd0;
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    send(8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, W);
    @(negedge clk);
    send(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, W);
    send(8'h01, 2'd3, 1'b0, 1'b0, 1'b1, W);
    @(negedge clk);
    send(8'h01, 2'd1, 1'b0, 1'b0, 1'b0, W);
    @(negedge clk);

    // abort mid-word with an asynchronous reset after bit 3
    send(8'hF0, 2'd1, 1'b0, 1'b0, 1'b0, 3);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("abort", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    last_ch = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.done", {done_l, done_m, en_l, en_m}, 4'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    send(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, W);
    @(negedge clk);

    send(8'h96, 2'd2, 1'b0, 1'b1, 1'b0, W);
    @(negedge clk);

    prev_hold = 1'b0;
    for (int t = 0; t < 24; t++) begin
      d    = 8'($urandom);
      c    = 2'($urandom);
      hold = 1'($urandom);
      scr  = (t % 3) == 0;
      send(d, c, hold, scr && !hold, prev_hold, W);
      prev_hold = hold;
      if (!hold) begin
        idle = $urandom_range(1, 3);
        for (int i = 0; i < idle; i++) begin
          @(negedge clk);
          chk_all("idle", 1'b0, 1'b0, 1'b0, last_ch, 1'b0, 1'b0, 1'b1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
